board_render_sequencer: RTL
===========================

Name: board_render_sequencer

Overview:
- Sequences the tile-to-text rendering datapath for the 2048 board.
- Snapshots the packed 320-bit board (16 tiles × 20 bits), then issues the tiles one at a time, in order, over a valid/ready handshake to the per-tile string formatter.
- Signals frame completion after the last tile.
- Buffers at most one pending board update that arrives while a frame is in flight. Newest update wins; displaced updates are counted as drops.

Parameters:
- TILES, 16, number of tiles per board. Fixed 4×4; RTL need only support 16.
- TILE_W, 20, bits per tile value. Board width = TILES*TILE_W = 320.
- SKIP_SAME, 1, when 1 an update equal to the last rendered board is ignored while idle.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- board  input  320  packed board; tile i = board[20*i+19 : 20*i]; i=0 top-left, row-major; value 0 = empty.
- board_valid  input  1  one-cycle strobe: board holds a new state this cycle.
- tile_value  output  20  value of the tile currently offered.
- tile_index  output  4  index of the tile currently offered.
- tile_valid  output  1  offer valid to the formatter.
- tile_ready  input  1  formatter accepts; handshake = tile_valid & tile_ready.
- render_busy  output  1  high from snapshot load until the frame_done cycle, inclusive.
- frame_done  output  1  one-cycle pulse after the tile 15 handshake.
- drop_count  output  8  saturating count of pending updates overwritten before render.

Behaviour:
- Reset (rst=1 at posedge): all outputs are 0, the FSM is in IDLE, the pending flag is cleared, and the last-rendered register is cleared to all-zero. rst overrides everything, including mid-frame. An in-flight offer is abandoned with no frame_done.
- Registers:
  - snap[319:0]: frame being rendered.
  - last[319:0]: last fully rendered frame.
  - pend[319:0] plus pend_v: one pending update.
  - idx[3:0].
  - state: IDLE, ISSUE, DONE.
- IDLE:
  - board_valid=1 with SKIP_SAME=1 and board==last: ignored; stay IDLE.
  - Otherwise board_valid=1: snap<=board, idx<=0, go to ISSUE.
  - Latency: strobe in cycle N gives tile_valid=1, tile_index=0 in cycle N+1.
- ISSUE:
  - tile_valid=1, tile_index=idx, tile_value=snap tile idx. All outputs are registered or decoded from registers only, with no combinational path from inputs to outputs.
  - Offer stays stable while tile_ready=0.
  - On handshake with idx<15: idx<=idx+1, and the next offer appears the following cycle.
  - Back-to-back ready gives 16 tiles in 16 consecutive cycles.
  - On handshake at idx==15: go to DONE; tile_valid=0 next cycle.
- DONE (exactly one cycle):
  - frame_done=1, render_busy=1, last<=snap.
  - If board_valid=1 this cycle: snap<=board, clear pend_v, go to ISSUE. The SKIP_SAME compare is against the just-completed snap.
  - Else if pend_v: snap<=pend, clear pend_v, go to ISSUE.
  - Else go to IDLE.
  - If board_valid=1 and pend_v are both set, board wins and drop_count increments.
- board_valid during ISSUE:
  - pend<=board and pend_v<=1. It never disturbs snap, so an in-flight frame is never torn.
  - If pend_v was already 1, drop_count increments (saturates at 255).
  - SKIP_SAME does not filter pending captures.
- render_busy: 1 in ISSUE and DONE, 0 in IDLE.
- idx wraps only via the reload to 0; no modulo arithmetic is relied on.

Test Plan:
- Reset, then board with tile i = i+1, board_valid pulse, tile_ready=1 constant -> indices 0..15 with values 1..16 in 16 consecutive cycles starting 1 cycle after the strobe; frame_done pulses for 1 cycle; render_busy falls the cycle after.
- Same frame with tile_ready toggling 1,0,0,1,... -> each offer held stable while ready=0; no index is skipped or repeated; frame_done occurs after exactly 16 handshakes.
- Three board_valid pulses (boards B1, B2, B3) during a frame -> after frame_done the next frame renders B3; drop_count=1; the B1 frame is unaffected.
- After rendering board B, re-strobe B while idle -> no tile_valid, render_busy stays 0. Strobe B with tile 5 = 2048 -> a full frame renders with tile 5 value 2048.
- Assert rst at tile_index=7 mid-frame -> the next cycle has tile_valid=0, render_busy=0, drop_count=0, and no frame_done. A subsequent strobe of the earlier board renders fully, because last was cleared.
- Strobe board_valid with B2 in the DONE cycle while pend_v holds B1 -> the next frame is B2 and drop_count increments by 1.

Source files
------------

// File: rtl/board_render_sequencer.sv
// Board render sequencer: snapshots a packed 4x4 board and offers its tiles one at a
// time over a valid/ready handshake, pulsing frame_done after the last tile. One board
// update arriving mid-frame is held pending; newer updates displace it and are counted.
module board_render_sequencer #(
   parameter int unsigned TILES     = 16,
   parameter int unsigned TILE_W    = 20,
   parameter bit          SKIP_SAME = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [TILES*TILE_W-1:0]   board,
   input  logic                      board_valid,
   output logic [TILE_W-1:0]         tile_value,
   output logic [3:0]                tile_index,
   output logic                      tile_valid,
   input  logic                      tile_ready,
   output logic                      render_busy,
   output logic                      frame_done,
   output logic [7:0]                drop_count
);

   localparam int unsigned BoardW  = TILES * TILE_W;
   localparam logic [3:0]  LastIdx = 4'(TILES - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

   state_e              state_q, state_d;
   logic [BoardW-1:0]   snap_q;
   logic [BoardW-1:0]   last_q;
   logic [BoardW-1:0]   pend_q;
   logic                pend_v_q;
   logic [3:0]          idx_q;
   logic [7:0]          drop_q;

   logic                handshake;
   logic                take_idle;
   logic                take_done;
   logic                drop_sat;

   // Decoded conditions shared by the FSM and the datapath
   always_comb begin
      handshake = (state_q == StIssue) && tile_ready;
      // Idle compares against the last rendered frame; DONE compares against the frame
      // just finishing, since last_q is only being written this cycle.
      take_idle = board_valid && !(SKIP_SAME && (board == last_q));
      take_done = board_valid && !(SKIP_SAME && (board == snap_q));
      drop_sat  = (drop_q == 8'hFF);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (take_idle) state_d = StIssue;
         end
         StIssue: begin
            if (handshake && (idx_q == LastIdx)) state_d = StDone;
         end
         StDone: begin
            state_d = (take_done || pend_v_q) ? StIssue : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Snapshot, pending buffer, tile index and drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_q   <= '0;
         last_q   <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         idx_q    <= 4'd0;
         drop_q   <= 8'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (take_idle) begin
                  snap_q <= board;
                  idx_q  <= 4'd0;
               end
            end
            StIssue: begin
               if (handshake && (idx_q != LastIdx)) idx_q <= idx_q + 4'd1;
               // Updates mid-frame never touch snap_q, so the frame cannot tear
               if (board_valid) begin
                  pend_q   <= board;
                  pend_v_q <= 1'b1;
                  if (pend_v_q && !drop_sat) drop_q <= drop_q + 8'd1;
               end
            end
            StDone: begin
               last_q <= snap_q;
               if (take_done) begin
                  snap_q   <= board;
                  idx_q    <= 4'd0;
                  pend_v_q <= 1'b0;
                  // Fresh board beats the pending one, which is lost
                  if (pend_v_q && !drop_sat) drop_q <= drop_q + 8'd1;
               end else if (pend_v_q) begin
                  snap_q   <= pend_q;
                  idx_q    <= 4'd0;
                  pend_v_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from registers only
   always_comb begin
      tile_valid  = (state_q == StIssue);
      render_busy = (state_q != StIdle);
      frame_done  = (state_q == StDone);
      tile_index  = idx_q;
      tile_value  = snap_q[idx_q*TILE_W +: TILE_W];
      drop_count  = drop_q;
   end

endmodule
